// File: rtl/wb_quad_encoder_if.sv
`timescale 1ns/1ps
// wb_quad_encoder_if
//   Wishbone slave bus bundle used by wb_quad_encoder.
//   Signals:
//     wb_cyc_i / wb_stb_i  bus cycle valid / strobe (master -> slave)
//     wb_we_i              1 = write, 0 = read
//     wb_addr_i            byte address
//     wb_data_i            write data
//     wb_data_o            read data, non-zero only while wb_ack_o = 1
//     wb_ack_o             single-cycle acknowledge
//   Modports: master (bus initiator), slave (the peripheral).
interface wb_quad_encoder_if #(
  parameter int unsigned C_WB_DWIDTH = 32
);
  logic                   wb_cyc_i;
  logic                   wb_stb_i;
  logic                   wb_we_i;
  logic [C_WB_DWIDTH-1:0] wb_addr_i;
  logic [C_WB_DWIDTH-1:0] wb_data_i;
  logic [C_WB_DWIDTH-1:0] wb_data_o;
  logic                   wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i,
    input  wb_data_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_data_i,
    output wb_data_o, wb_ack_o
  );
endinterface

// File: rtl/wb_quad_encoder.sv
`timescale 1ns/1ps
// wb_quad_encoder
//   Multi-channel 4x quadrature encoder decoder behind a Wishbone slave.
//   Each channel synchronises its A/B pins, decodes steps into a signed,
//   wrapping position counter, flags illegal (double-bit) transitions and
//   feeds sticky, maskable change/error status bits into one level irq.
//   Register window (byte offsets from C_BASEADDR):
//     0x00 CTRL   [C_NUM_CH-1:0] chg-irq en, [C_NUM_CH+7:8] err-irq en, [31] count en
//     0x04 STATUS [C_NUM_CH-1:0] chg sticky, [C_NUM_CH+7:8] err sticky (write 1 clears)
//     0x08 RAW    [2n+1:2n] = {A,B} of channel n as seen by the decoder
//     0x10+4n     CNT_n, zero-extended; a write loads the counter
//   Ports:
//     wb_clk_i  clock, rising edge
//     wb_rst_i  asynchronous active-high reset
//     wb        Wishbone slave modport
//     irq_o     registered level interrupt
//     enc_a/b   asynchronous encoder pins, one bit per channel
//   Optional build macro WB_QENC_FILTER_EN adds a per-pin glitch filter
//   (C_FILT_LEN consecutive clocks of a new level before it is accepted).
module wb_quad_encoder #(
  parameter int unsigned             C_WB_DWIDTH = 32,
  parameter logic [C_WB_DWIDTH-1:0]  C_BASEADDR  = '0,
  parameter int unsigned             C_NUM_CH    = 4,
  parameter int unsigned             C_CNT_WIDTH = 16,
  parameter int unsigned             C_FILT_LEN  = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_quad_encoder_if.slave    wb,
  output logic                irq_o,
  input  logic [C_NUM_CH-1:0] enc_a,
  input  logic [C_NUM_CH-1:0] enc_b
);

  // Position of an {A,B} pair along the forward cycle 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  logic [C_WB_DWIDTH-1:0] off;
  logic                   req;
  logic                   wr;
  logic                   ctrl_sel;
  logic                   status_sel;
  logic                   raw_sel;
  logic [C_NUM_CH-1:0]    cnt_sel;

  logic                   ack_reg;
  logic [C_WB_DWIDTH-1:0] rdata_reg;
  logic                   irq_reg;
  logic                   primed_reg;
  logic [C_NUM_CH-1:0]    chg_en_reg;
  logic [C_NUM_CH-1:0]    err_en_reg;
  logic                   count_en_reg;
  logic [C_NUM_CH-1:0]    chg_reg;
  logic [C_NUM_CH-1:0]    err_reg;

  logic [C_NUM_CH-1:0]    chg_set;
  logic [C_NUM_CH-1:0]    err_set;
  logic [C_NUM_CH-1:0]    chg_clr;
  logic [C_NUM_CH-1:0]    err_clr;
  logic [2*C_NUM_CH-1:0]  raw;
  logic [C_CNT_WIDTH-1:0] cnt_val [C_NUM_CH];
  logic [C_WB_DWIDTH-1:0] rd_data;

  // Only some write-data bits are architected; the rest are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^wb.wb_data_i;

  assign off        = wb.wb_addr_i - C_BASEADDR;
  assign req        = wb.wb_cyc_i & wb.wb_stb_i & ~ack_reg;
  assign wr         = req & wb.wb_we_i;
  assign ctrl_sel   = (off == C_WB_DWIDTH'(0));
  assign status_sel = (off == C_WB_DWIDTH'(4));
  assign raw_sel    = (off == C_WB_DWIDTH'(8));

  assign chg_clr = (wr && status_sel) ? wb.wb_data_i[C_NUM_CH-1:0]   : '0;
  assign err_clr = (wr && status_sel) ? wb.wb_data_i[C_NUM_CH+7:8]   : '0;

  genvar gi;
  generate
    for (gi = 0; gi < C_NUM_CH; gi++) begin : g_ch
      logic [1:0]             sync1_reg;
      logic [1:0]             sync2_reg;
      logic [1:0]             prev_reg;
      logic [1:0]             cur;
      logic [1:0]             delta;
      logic [C_CNT_WIDTH-1:0] cnt_reg;
      logic                   step_fwd;
      logic                   step_rev;
      logic                   cnt_load;

      assign cnt_sel[gi] = (off == C_WB_DWIDTH'(16 + 4 * gi));

      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          sync1_reg <= '0;
          sync2_reg <= '0;
        end else begin
          sync1_reg <= {enc_a[gi], enc_b[gi]};
          sync2_reg <= sync1_reg;
        end
      end

`ifdef WB_QENC_FILTER_EN
      logic [1:0] filt_reg;
      logic [3:0] fcnt_reg [2];

      // A new level is accepted on the C_FILT_LEN-th consecutive differing
      // clock; any return to the filtered level restarts the count.
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          filt_reg <= '0;
          for (int p = 0; p < 2; p++) fcnt_reg[p] <= '0;
        end else begin
          for (int p = 0; p < 2; p++) begin
            if (sync2_reg[p] != filt_reg[p]) begin
              if (fcnt_reg[p] == 4'(C_FILT_LEN - 1)) begin
                filt_reg[p] <= sync2_reg[p];
                fcnt_reg[p] <= '0;
              end else begin
                fcnt_reg[p] <= fcnt_reg[p] + 4'd1;
              end
            end else begin
              fcnt_reg[p] <= '0;
            end
          end
        end
      end
      assign cur = filt_reg;
`else
      assign cur = sync2_reg;
`endif

      // delta 1 = forward, 3 = reverse, 2 = both pins moved (illegal).
      assign delta    = gray_pos(cur) - gray_pos(prev_reg);
      assign step_fwd = primed_reg && (delta == 2'd1);
      assign step_rev = primed_reg && (delta == 2'd3);
      assign cnt_load = wr && cnt_sel[gi];

      // A bus load on the same edge as a step wins; the step is lost and
      // therefore does not mark a change either.
      assign chg_set[gi] = count_en_reg && (step_fwd || step_rev) && !cnt_load;
      assign err_set[gi] = primed_reg && (delta == 2'd2);

      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
          prev_reg <= '0;
          cnt_reg  <= '0;
        end else begin
          prev_reg <= cur;
          if (cnt_load) begin
            cnt_reg <= wb.wb_data_i[C_CNT_WIDTH-1:0];
          end else if (count_en_reg && step_fwd) begin
            cnt_reg <= cnt_reg + C_CNT_WIDTH'(1);
          end else if (count_en_reg && step_rev) begin
            cnt_reg <= cnt_reg - C_CNT_WIDTH'(1);
          end
        end
      end

      assign raw[2*gi +: 2] = cur;
      assign cnt_val[gi]    = cnt_reg;
    end
  endgenerate

`ifndef WB_QENC_FILTER_EN
  localparam int unsigned filt_len_unused = C_FILT_LEN;
`endif

  always_comb begin
    rd_data = '0;
    if (ctrl_sel) begin
      rd_data[C_NUM_CH-1:0] = chg_en_reg;
      rd_data[C_NUM_CH+7:8] = err_en_reg;
      rd_data[31]           = count_en_reg;
    end else if (status_sel) begin
      rd_data[C_NUM_CH-1:0] = chg_reg;
      rd_data[C_NUM_CH+7:8] = err_reg;
    end else if (raw_sel) begin
      rd_data[2*C_NUM_CH-1:0] = raw;
    end else begin
      for (int n = 0; n < C_NUM_CH; n++) begin
        if (cnt_sel[n]) rd_data[C_CNT_WIDTH-1:0] = cnt_val[n];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_reg      <= 1'b0;
      rdata_reg    <= '0;
      irq_reg      <= 1'b0;
      primed_reg   <= 1'b0;
      chg_en_reg   <= '0;
      err_en_reg   <= '0;
      count_en_reg <= 1'b0;
      chg_reg      <= '0;
      err_reg      <= '0;
    end else begin
      primed_reg <= 1'b1;
      ack_reg    <= req;
      rdata_reg  <= req ? rd_data : '0;
      if (wr && ctrl_sel) begin
        chg_en_reg   <= wb.wb_data_i[C_NUM_CH-1:0];
        err_en_reg   <= wb.wb_data_i[C_NUM_CH+7:8];
        count_en_reg <= wb.wb_data_i[31];
      end
      // Set events take priority over a same-edge write-1-to-clear.
      chg_reg <= (chg_reg & ~chg_clr) | chg_set;
      err_reg <= (err_reg & ~err_clr) | err_set;
      irq_reg <= (|(chg_reg & chg_en_reg)) | (|(err_reg & err_en_reg));
    end
  end

  assign wb.wb_ack_o  = ack_reg;
  assign wb.wb_data_o = rdata_reg;
  assign irq_o        = irq_reg;

endmodule

// File: tb/tb_wb_quad_encoder.sv
`timescale 1ns/1ps
// tb_wb_quad_encoder
//   Self-checking bench for wb_quad_encoder: directed scenarios followed by
//   randomized pin/register activity, all compared against a transaction
//   level model of counts, sticky bits and irq.
module tb_wb_quad_encoder;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int NCH  = 4;
  localparam int FILT = 4;
`ifdef WB_QENC_FILTER_EN
  localparam int LAT = 3 + FILT;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  logic [NCH-1:0] enc_a = '0;
  logic [NCH-1:0] enc_b = '0;

  wb_quad_encoder_if #(.C_WB_DWIDTH(32)) bus();

  wb_quad_encoder #(
    .C_WB_DWIDTH(32), .C_BASEADDR(BASE), .C_NUM_CH(NCH),
    .C_CNT_WIDTH(16), .C_FILT_LEN(FILT)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus.slave),
    .irq_o(irq), .enc_a(enc_a), .enc_b(enc_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  logic [15:0] m_cnt [NCH];
  logic [1:0]  m_pin [NCH];
  logic [NCH-1:0] m_chg, m_err, m_chg_en, m_err_en;
  logic m_cnt_en;
  logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int pos_of(input logic [1:0] v);
    case (v)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) m_cnt[c] = '0;
    m_chg = '0; m_err = '0; m_chg_en = '0; m_err_en = '0; m_cnt_en = 1'b0;
  endtask

  task automatic model_ctrl(input logic [31:0] d);
    m_chg_en = d[NCH-1:0]; m_err_en = d[NCH+7:8]; m_cnt_en = d[31];
  endtask

  task automatic model_w1c(input logic [31:0] d);
    m_chg = m_chg & ~d[NCH-1:0]; m_err = m_err & ~d[NCH+7:8];
  endtask

  // Move a channel's pins to nv and account for the resulting step.
  task automatic model_move(input int ch, input logic [1:0] nv, input bit counted);
    int d;
    d = (pos_of(nv) - pos_of(m_pin[ch]) + 4) % 4;
    if (d == 2) m_err[ch] = 1'b1;
    else if (d != 0 && m_cnt_en && counted) begin
      m_cnt[ch] = (d == 1) ? m_cnt[ch] + 16'd1 : m_cnt[ch] - 16'd1;
      m_chg[ch] = 1'b1;
    end
    m_pin[ch] = nv;
    enc_a[ch] = nv[1];
    enc_b[ch] = nv[0];
  endtask

  task automatic step_to(input int ch, input logic [1:0] nv);
    model_move(ch, nv, 1'b1);
    repeat (LAT + 1) tick();
  endtask

  task automatic bus_xfer(input logic we, input logic [31:0] off, input logic [31:0] wd,
                          output logic [31:0] rd);
    int waited;
    waited = 0;
    rd = '0;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_addr_i = BASE + off; bus.wb_data_i = wd;
    do begin
      tick();
      waited++;
    end while (!bus.wb_ack_o && waited < 8);
    check_eq("ack", {31'b0, bus.wb_ack_o}, 32'd1);
    rd = bus.wb_data_o;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] off, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_xfer(1'b1, off, wd, dummy);
  endtask

  task automatic wb_read(input logic [31:0] off, output logic [31:0] rd);
    bus_xfer(1'b0, off, 32'h0, rd);
  endtask

  function automatic logic [31:0] exp_ctrl();
    logic [31:0] v;
    v = '0; v[NCH-1:0] = m_chg_en; v[NCH+7:8] = m_err_en; v[31] = m_cnt_en;
    return v;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] v;
    v = '0; v[NCH-1:0] = m_chg; v[NCH+7:8] = m_err;
    return v;
  endfunction

  function automatic logic [31:0] exp_raw();
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[2*c +: 2] = m_pin[c];
    return v;
  endfunction

  function automatic logic exp_irq();
    return (|(m_chg & m_chg_en)) | (|(m_err & m_err_en));
  endfunction

  task automatic check_all(input int ch);
    logic [31:0] rd;
    wb_read(32'h0, rd);  check_eq("ctrl", rd, exp_ctrl());
    wb_read(32'h4, rd);  check_eq("status", rd, exp_status());
    wb_read(32'h8, rd);  check_eq("raw", rd, exp_raw());
    wb_read(32'h10 + 4 * ch, rd);
    check_eq($sformatf("cnt%0d", ch), rd, {16'h0, m_cnt[ch]});
    tick();
    check_eq("irq", {31'b0, irq}, {31'b0, exp_irq()});
  endtask

  initial begin : main
    logic [31:0] rd;
    int acks;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_addr_i = '0; bus.wb_data_i = '0;
    for (int c = 0; c < NCH; c++) m_pin[c] = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // Reset state
    check_eq("rst_ack", {31'b0, bus.wb_ack_o}, 32'd0);
    check_eq("rst_data", bus.wb_data_o, 32'd0);
    check_eq("rst_irq", {31'b0, irq}, 32'd0);
    check_all(0);

    // Eight forward steps on ch0 with counting enabled, irq masked
    wb_write(32'h0, 32'h8000_0000); model_ctrl(32'h8000_0000);
    for (int i = 0; i < 8; i++) step_to(0, gray[(pos_of(m_pin[0]) + 1) % 4]);
    wb_read(32'h10, rd); check_eq("fwd8_cnt0", rd, 32'd8);
    wb_read(32'h4, rd);  check_eq("fwd8_chg0", {31'b0, rd[0]}, 32'd1);
    check_eq("fwd8_irq", {31'b0, irq}, 32'd0);

    // Wrap both ways on ch1
    wb_write(32'h14, 32'h0); m_cnt[1] = 16'h0;
    step_to(1, 2'b10);
    wb_read(32'h14, rd); check_eq("wrap_down", rd, 32'h0000_FFFF);
    step_to(1, 2'b00);
    wb_read(32'h14, rd); check_eq("wrap_up", rd, 32'h0);

    // Illegal jump on ch2, error irq, W1C
    step_to(2, 2'b11);
    wb_read(32'h4, rd);  check_eq("err2_sticky", {31'b0, rd[10]}, 32'd1);
    wb_read(32'h18, rd); check_eq("err2_cnt", rd, {16'h0, m_cnt[2]});
    wb_write(32'h0, 32'h8000_0400); model_ctrl(32'h8000_0400);
    tick();
    check_eq("err2_irq", {31'b0, irq}, 32'd1);
    wb_write(32'h4, 32'h400); model_w1c(32'h400);
    check_eq("w1c_irq_lag", {31'b0, irq}, 32'd1);
    tick();
    check_eq("w1c_irq_clr", {31'b0, irq}, 32'd0);
    step_to(2, 2'b10);
    step_to(2, 2'b00);
    check_all(2);

    // CNT_0 write lands on the same edge as a forward step: write wins
    model_move(0, 2'b01, 1'b0);
    repeat (LAT - 1) tick();
    wb_write(32'h10, 32'h55); m_cnt[0] = 16'h55;
    repeat (LAT + 1) tick();
    check_all(0);

    // Pin-to-counter latency boundary
    model_move(0, 2'b11, 1'b0);
    repeat (LAT - 1) tick();
    wb_read(32'h10, rd); check_eq("lat_before", rd, 32'h55);
    wb_read(32'h10, rd); check_eq("lat_after", rd, 32'h56);
    m_cnt[0] = 16'h56;

`ifdef WB_QENC_FILTER_EN
    // Short glitch is rejected by the filter
    enc_a[0] = ~m_pin[0][1];
    repeat (3) tick();
    enc_a[0] = m_pin[0][1];
    repeat (LAT + 2) tick();
    wb_read(32'h10, rd); check_eq("glitch_cnt", rd, {16'h0, m_cnt[0]});
    step_to(0, 2'b10);
    check_all(0);
`endif

    // Held strobe: ack every second cycle
    acks = 0;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_addr_i = BASE;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.wb_ack_o) acks++;
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    tick();
    check_eq("held_acks", acks, 32'd3);

    // Unmapped offsets
    wb_read(32'h40, rd); check_eq("unmapped_40", rd, 32'h0);
    wb_read(32'hFFFF_FFFC, rd); check_eq("unmapped_m4", rd, 32'h0);
    wb_write(32'h40, 32'hFFFF_FFFF);
    check_all(3);

    // Return pins to 00, then async reset in the middle of an acked read
    for (int c = 0; c < NCH; c++) step_to(c, 2'b00);
    wb_write(32'h0, 32'h8000_000F); model_ctrl(32'h8000_000F);
    tick(); tick();
    check_eq("pre_rst_irq", {31'b0, irq}, {31'b0, exp_irq()});
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_addr_i = BASE;
    tick();
    check_eq("pre_rst_data", bus.wb_data_o, 32'h8000_000F);
    #2 rst = 1'b1;
    #1;
    check_eq("async_ack", {31'b0, bus.wb_ack_o}, 32'd0);
    check_eq("async_data", bus.wb_data_o, 32'd0);
    check_eq("async_irq", {31'b0, irq}, 32'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
    tick();
    check_all(0);

    // Randomized activity
    for (int it = 0; it < 80; it++) begin
      int op;
      int ch;
      logic [31:0] d;
      op = $urandom_range(0, 4);
      ch = $urandom_range(0, NCH - 1);
      d  = $urandom;
      case (op)
        0, 1: begin
          for (int c = 0; c < NCH; c++)
            if ($urandom_range(0, 1) == 1) model_move(c, 2'($urandom_range(0, 3)), 1'b1);
          repeat (LAT + 1) tick();
        end
        2: begin
          wb_write(32'h10 + 4 * ch, d); m_cnt[ch] = d[15:0];
        end
        3: begin
          d[31] = ($urandom_range(0, 3) != 0);
          wb_write(32'h0, d); model_ctrl(d);
        end
        default: begin
          wb_write(32'h4, d); model_w1c(d);
        end
      endcase
      check_all(ch);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not finish");
  end
endmodule
